// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier, one multiplier bit per cycle, unsigned or two's-complement.
// Optional build macro SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mult_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     ain,
    input  logic [WIDTH-1:0]     bin,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   yout
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   yout_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sign_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     amag_d;
    logic [WIDTH-1:0]     bmag_d;
    logic [2*WIDTH-1:0]   sum_d;
    logic [2*WIDTH-1:0]   result_d;
    logic                 last_d;

    // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is still correct unsigned.
    always_comb begin
        amag_d   = (tc && ain[WIDTH-1]) ? (~ain + 1'b1) : ain;
        bmag_d   = (tc && bin[WIDTH-1]) ? (~bin + 1'b1) : bin;
        sum_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        result_d = sign_q ? (~sum_d + 1'b1) : sum_d;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        last_d   = (cnt_q == CNT_W'(WIDTH-1)) || ((mplier_q >> 1) == '0);
`else
        last_d   = (cnt_q == CNT_W'(WIDTH-1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            yout_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, amag_d};
                        mplier_q <= bmag_d;
                        sign_q   <= tc & (ain[WIDTH-1] ^ bin[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= CALC;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q    <= sum_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_d) begin
                        yout_q  <= result_d;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign yout  = yout_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: randomized operands against an arithmetic reference model.
module tb_seq_mult_param;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             tc;
    logic [W-1:0]     ain;
    logic [W-1:0]     bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   yout;

    int checks = 0;
    int errors = 0;

    seq_mult_param #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .tc    (tc),
        .ain   (ain),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .yout  (yout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic t);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (t && a[W-1]) sa = sa - (longint'(1) <<< W);
        if (t && b[W-1]) sb = sb - (longint'(1) <<< W);
        p = sa * sb;
        return p[2*W-1:0];
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b, input logic t);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        longint mag;
        int hb;
        mag = longint'(b);
        if (t && b[W-1]) mag = (longint'(1) <<< W) - mag;
        hb = 0;
        for (int i = 0; i < int'(W); i++) if (mag[i]) hb = i;
        return hb + 1;
`else
        return (b == b) ? int'(W) : 0;
`endif
    endfunction

    // Drives one operation; after capture the inputs are scrambled to prove they are not re-sampled.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic t,
                          output int lat_seen, output logic [2*W-1:0] y,
                          output bit hs_ok, output bit hold_ok, output bit after_ok);
        logic [2*W-1:0] prev;
        int n;
        @(negedge clk);
        prev = yout;
        ain = a; bin = b; tc = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ain = W'($urandom); bin = W'($urandom); tc = 1'($urandom);
        hs_ok = 1'b1; hold_ok = 1'b1; lat_seen = -1; n = 0;
        while (n < int'(W) + 4) begin
            if (!(busy === 1'b1 && ready === 1'b0)) hs_ok = 1'b0;
            if (done === 1'b1) begin lat_seen = n; break; end
            if (yout !== prev) hold_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        y = yout;
        @(posedge clk); #1;
        after_ok = (done === 1'b0) && (ready === 1'b1) && (busy === 1'b0) && (yout === y);
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic t);
        int lat; logic [2*W-1:0] y; bit hs, hold, aft;
        run_op(a, b, t, lat, y, hs, hold, aft);
        checks++;
        if (y !== ref_prod(a, b, t)) begin
            errors++;
            $display("FAIL %s product a=%h b=%h tc=%0d: got %h expected %h", name, a, b, t, y, ref_prod(a, b, t));
        end
        checks++;
        if (lat !== ref_lat(b, t)) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, ref_lat(b, t));
        end
        checks++;
        if ({hs, hold, aft} !== 3'b111) begin
            errors++;
            $display("FAIL %s handshake busy/hold/after: got %b expected 111", name, {hs, hold, aft});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; tc = 1'b0; ain = '0; bin = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ready, busy, done, yout} !== {3'b100, {(2*W){1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got rdy/busy/done=%b%b%b yout=%h expected 100 yout=0", ready, busy, done, yout);
        end
    endtask

    task automatic test_directed;
        check_op("unsigned_max", '1, '1, 1'b0);
        check_op("signed_mixed", -W'(3), W'(7), 1'b1);
        check_op("min_x_min", {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b1);
        check_op("min_x_one", {1'b1, {(W-1){1'b0}}}, W'(1), 1'b1);
        check_op("min_x_neg1", {1'b1, {(W-1){1'b0}}}, '1, 1'b1);
        check_op("zero_b", W'(16'h7F), '0, 1'b1);
        check_op("zero_a", '0, W'(16'h1234), 1'b0);
        check_op("small_b", W'(16'h7F), W'(3), 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            check_op("random", W'($urandom), W'($urandom >> $urandom_range(0, 15)), 1'($urandom));
    endtask

    task automatic test_ignore_start;
        int n; int dones; logic [2*W-1:0] y;
        @(negedge clk);
        ain = W'(2); bin = '1; tc = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        ain = W'(9); bin = W'(5); start = 1'b1;
        @(negedge clk); start = 1'b0;
        dones = 0; n = 0; y = '0;
        while (n < 3 * int'(W)) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin dones++; y = yout; end
            n++;
        end
        checks++;
        if (dones !== 1 || y !== ref_prod(W'(2), '1, 1'b0)) begin
            errors++;
            $display("FAIL ignore_start: got %0d done pulses yout=%h expected 1 pulse yout=%h", dones, y, ref_prod(W'(2), '1, 1'b0));
        end
        check_op("after_ignore", W'(2), W'(3), 1'b0);
    endtask

    task automatic test_back_to_back;
        int edges[$]; logic [2*W-1:0] ys[$]; logic [W-1:0] a, b; logic t; int n;
        a = W'($urandom); b = W'($urandom) | {1'b1, {(W-1){1'b0}}}; t = 1'($urandom);
        @(negedge clk);
        ain = a; bin = b; tc = t; start = 1'b1;
        n = 0;
        while (n < 4 * int'(W) + 10 && edges.size() < 3) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin edges.push_back(n); ys.push_back(yout); end
            n++;
        end
        start = 1'b0;
        checks++;
        if (edges.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses expected 3", edges.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (edges[i] !== ref_lat(b, t) + i * (ref_lat(b, t) + 2) || ys[i] !== ref_prod(a, b, t)) begin
                    errors++;
                    $display("FAIL b2b_op%0d: got edge %0d yout=%h expected edge %0d yout=%h", i, edges[i], ys[i],
                             ref_lat(b, t) + i * (ref_lat(b, t) + 2), ref_prod(a, b, t));
                end
            end
        end
        repeat (int'(W) + 4) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ain = '1; bin = '1; tc = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, busy, done, yout} !== {3'b100, {(2*W){1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid: got rdy/busy/done=%b%b%b yout=%h expected 100 yout=0", ready, busy, done, yout);
        end
        @(negedge clk); rst_n = 1'b1;
        check_op("post_reset", W'(16'h1234), W'(16'h0010), 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
